// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Staged reset sequencer for the clk_sys domain. Synchronizes the PLL lock
//   and the board button, debounces the button, and combines them with the
//   software request into a single reset request. A three-state FSM
//   (HOLD -> REL_PERIPH -> RUN) stretches the reset, releases the peripherals
//   first and the core STAGE_GAP cycles later. The cause of the most recent
//   reset and a saturating event counter are kept for the status block.
//
// Ports
//   clk_sys        in  system clock (only clock)
//   rst_sys        in  synchronous active-high reset
//   pll_locked_i   in  PLL lock, asynchronous
//   btn_rst_ni     in  board reset button, active-low, asynchronous
//   sw_rst_req_i   in  single-cycle software reset request (clk_sys domain)
//   rst_periph_no  out peripheral reset, active-low, registered
//   rst_core_no    out core reset, active-low, registered
//   reset_active_o out high unless the FSM is in RUN
//   reset_cause_o  out last cause: 00 power-on, 01 lock loss, 10 button, 11 sw
//   reset_count_o  out saturating count of reset events since rst_sys
module rst_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 64,
  parameter int STAGE_GAP       = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             pll_locked_i,
  input  logic             btn_rst_ni,
  input  logic             sw_rst_req_i,
  output logic             rst_periph_no,
  output logic             rst_core_no,
  output logic             reset_active_o,
  output logic [1:0]       reset_cause_o,
  output logic [CNT_W-1:0] reset_count_o
);

  localparam int SEQ_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(SEQ_MAX) + 1;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    REL_PERIPH = 2'd1,
    RUN        = 2'd2
  } state_e;

  // Synchronizers and debounce
  logic          lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
  logic          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic          btn_db_q, btn_db_d;     // 1 = released
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  // Sequencer
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req;
  logic          event_hit;

  // Registered outputs
  logic             periph_q, periph_d;
  logic             core_q, core_d;
  logic             active_q, active_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Input conditioning: 2-flop synchronizers, then a debounce that only flips
  // after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    lock_s1_d = pll_locked_i;
    lock_s2_d = lock_s1_q;
    btn_s1_d  = btn_rst_ni;
    btn_s2_d  = btn_s1_q;
    btn_db_d  = btn_db_q;
    db_cnt_d  = '0;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign req       = ~lock_s2_q | ~btn_db_q | sw_rst_req_i;
  // A request only counts as a new event once the sequence has left HOLD.
  assign event_hit = req & (state_q != HOLD);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (req) begin
          cnt_d = STRETCH_LOAD;
        end else if (cnt_q == '0) begin
          state_d = REL_PERIPH;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REL_PERIPH: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = STRETCH_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = STRETCH_LOAD;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = STRETCH_LOAD;
      end
    endcase
  end

  // Output logic: decoded from the next state so outputs are registered and
  // change on the same edge as the state, which keeps them glitch-free.
  always_comb begin
    periph_d = (state_d != HOLD);
    core_d   = (state_d == RUN);
    active_d = (state_d != RUN);
    cause_d  = cause_q;
    count_d  = count_q;
    if (event_hit) begin
      if (!lock_s2_q) begin
        cause_d = 2'b01;
      end else if (!btn_db_q) begin
        cause_d = 2'b10;
      end else begin
        cause_d = 2'b11;
      end
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      btn_db_q  <= 1'b1;
      db_cnt_q  <= '0;
      state_q   <= HOLD;
      cnt_q     <= '0;
      periph_q  <= 1'b0;
      core_q    <= 1'b0;
      active_q  <= 1'b1;
      cause_q   <= 2'b00;
      count_q   <= '0;
    end else begin
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      btn_db_q  <= btn_db_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      periph_q  <= periph_d;
      core_q    <= core_d;
      active_q  <= active_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
    end
  end

  assign rst_periph_no  = periph_q;
  assign rst_core_no    = core_q;
  assign reset_active_o = active_q;
  assign reset_cause_o  = cause_q;
  assign reset_count_o  = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  localparam int S = 64;
  localparam int G = 8;
  localparam int D = 16;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       rst_sys, pll_locked_i, btn_rst_ni, sw_rst_req_i;
  logic       rst_periph_no, rst_core_no, reset_active_o;
  logic [1:0] reset_cause_o;
  logic [7:0] reset_count_o;
  logic       p2_periph, p2_core, p2_active;
  logic [1:0] p2_cause;
  logic [1:0] p2_count;

  rst_sequencer #(.DEBOUNCE_CYCLES(D), .STRETCH_CYCLES(S), .STAGE_GAP(G), .CNT_W(8)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .pll_locked_i(pll_locked_i),
    .btn_rst_ni(btn_rst_ni), .sw_rst_req_i(sw_rst_req_i),
    .rst_periph_no(rst_periph_no), .rst_core_no(rst_core_no),
    .reset_active_o(reset_active_o), .reset_cause_o(reset_cause_o),
    .reset_count_o(reset_count_o)
  );

  // Narrow counter instance to exercise saturation.
  rst_sequencer #(.DEBOUNCE_CYCLES(D), .STRETCH_CYCLES(S), .STAGE_GAP(G), .CNT_W(2)) dut2 (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .pll_locked_i(pll_locked_i),
    .btn_rst_ni(btn_rst_ni), .sw_rst_req_i(sw_rst_req_i),
    .rst_periph_no(p2_periph), .rst_core_no(p2_core),
    .reset_active_o(p2_active), .reset_cause_o(p2_cause),
    .reset_count_o(p2_count)
  );

  typedef struct {
    logic       periph;
    logic       core;
    logic       active;
    logic [1:0] cause;
    int         count;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: synchronizer delay as a 2-deep queue, debounce as a
  // run length, sequencing from the distance to the last request cycle.
  logic    lock_pipe[$];
  logic    btn_pipe[$];
  logic    db_state;
  int      db_run;
  longint  t = 0;
  longint  last_req;
  logic    m_periph, m_core;
  logic [1:0] m_cause;
  int      m_count;

  longint  pon_base = -1;
  longint  periph_rise = -1;
  longint  core_rise = -1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, t, act, exp_v);
    end
  endtask

  task automatic model_reset();
    lock_pipe = '{1'b0, 1'b0};
    btn_pipe  = '{1'b1, 1'b1};
    db_state  = 1'b1;
    db_run    = 0;
    m_periph  = 1'b0;
    m_core    = 1'b0;
    m_cause   = 2'b00;
    m_count   = 0;
    last_req  = t + 1;
  endtask

  task automatic model_step(input logic rst, input logic lock, input logic btn, input logic sw);
    exp_t e;
    logic ls, bs, req;
    if (rst) begin
      model_reset();
    end else begin
      ls = lock_pipe.pop_front();
      lock_pipe.push_back(lock);
      bs = btn_pipe.pop_front();
      btn_pipe.push_back(btn);
      req = !ls || !db_state || sw;
      if (req) begin
        if (m_periph) begin
          m_cause = !ls ? 2'b01 : (!db_state ? 2'b10 : 2'b11);
          if (m_count < 255) m_count++;
        end
        last_req = t;
      end
      if (bs != db_state) begin
        db_run++;
        if (db_run == D) begin
          db_state = bs;
          db_run   = 0;
        end
      end else begin
        db_run = 0;
      end
      m_periph = ((t + 1 - last_req) >= S + 1);
      m_core   = ((t + 1 - last_req) >= S + G + 1);
    end
    e.periph = m_periph;
    e.core   = m_core;
    e.active = !m_core;
    e.cause  = m_cause;
    e.count  = m_count;
    sb_q.push_back(e);
    t++;
  endtask

  task automatic drive(input logic rst, input logic lock, input logic btn, input logic sw);
    @(negedge clk_sys);
    rst_sys      = rst;
    pll_locked_i = lock;
    btn_rst_ni   = btn;
    sw_rst_req_i = sw;
    model_step(rst, lock, btn, sw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Wait (bounded) until the model is in the peripheral-released, core-held window.
  task automatic wait_rel(input string name);
    int n = 0;
    while (!(m_periph && !m_core) && n < 300) begin
      idle(1);
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (!m_core && n < 300) begin
      idle(1);
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: outputs are present every cycle; compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rst_periph_no", int'(rst_periph_no), int'(e.periph));
        chk("rst_core_no", int'(rst_core_no), int'(e.core));
        chk("reset_active_o", int'(reset_active_o), int'(e.active));
        chk("reset_cause_o", int'(reset_cause_o), int'(e.cause));
        chk("reset_count_o", int'(reset_count_o), e.count);
        chk("count_sat_w2", int'(p2_count), (e.count > 3) ? 3 : e.count);
        chk("periph_w2", int'(p2_periph), int'(e.periph));
        if (rst_core_no && !rst_periph_no) chk("core_before_periph", 1, 0);
        if (pon_base >= 0 && periph_rise < 0 && rst_periph_no) periph_rise = t - pon_base;
        if (pon_base >= 0 && core_rise < 0 && rst_core_no) core_rise = t - pon_base;
      end
    end
  end

  initial begin
    int lock_left, btn_left;
    logic r_rst, r_sw;
    rst_sys = 1'b1; pll_locked_i = 1'b1; btn_rst_ni = 1'b1; sw_rst_req_i = 1'b0;

    // Power-on
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    pon_base = t;
    idle(80);
    chk("pon_periph_rise_cycle", int'(periph_rise), 66);
    chk("pon_core_rise_cycle", int'(core_rise), 74);
    pon_base = -1;

    // Lock loss for one cycle while running
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(90);

    // Short button press ignored, long press resets
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(110);

    // Software request during peripheral-only window
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    wait_rel("sw_rel");
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    idle(100);

    // Lock loss and software request reaching the FSM in the same cycle
    wait_run("simul_run");
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    idle(90);

    // More events to saturate the narrow counter
    for (int k = 0; k < 3; k++) begin
      wait_run("sat_run");
      drive(1'b0, 1'b1, 1'b1, 1'b1);
    end
    wait_run("sat_end");

    // rst_sys pulse mid-sequence
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    wait_rel("rstsys_rel");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    idle(100);

    // Randomized traffic
    lock_left = 0;
    btn_left  = 0;
    for (int i = 0; i < 5000; i++) begin
      if (lock_left == 0 && $urandom_range(0, 299) == 0) lock_left = $urandom_range(1, 3);
      if (btn_left == 0 && $urandom_range(0, 199) == 0) btn_left = $urandom_range(1, 45);
      r_sw  = ($urandom_range(0, 99) == 0);
      r_rst = ($urandom_range(0, 1499) == 0);
      drive(r_rst, lock_left == 0, btn_left == 0, r_sw);
      if (lock_left > 0) lock_left--;
      if (btn_left > 0) btn_left--;
    end
    idle(2);
    @(posedge clk_sys);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
